// File: rtl/microprocessor_pkg.sv
// Shared opcode and FSM state encodings for the switch/button arithmetic processor.
// Latency: n/a (constants only). Backpressure: n/a.
package microprocessor_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser + optional debouncer (DEBOUNCE_EN) + rising-edge detector -> one-cycle start pulse.
// Latency: start_vld 3 cycles after btn rises (plus DBNC_CYCLES with DEBOUNCE_EN).
// Backpressure: none; a held button yields exactly one pulse.
module btn_sync_edge #(
    parameter int DBNC_CYCLES = 1000000
) (
    input  logic core_clk,
    input  logic rst,
    input  logic btn,
    output logic start_vld
);

    logic sync0;
    logic sync1;
    logic lvl;
    logic lvl_d;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DBNC_CYCLES + 1);
    logic [CW-1:0] dbnc_cnt;
    logic          dbnc_lvl;

    // Counter measures how long sync1 has disagreed with the accepted level.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            dbnc_cnt <= '0;
            dbnc_lvl <= 1'b0;
        end else if (sync1 == dbnc_lvl) begin
            dbnc_cnt <= '0;
        end else if (dbnc_cnt == CW'(DBNC_CYCLES - 1)) begin
            dbnc_cnt <= '0;
            dbnc_lvl <= sync1;
        end else begin
            dbnc_cnt <= dbnc_cnt + CW'(1);
        end
    end

    assign lvl = dbnc_lvl;
`else
    logic unused_dbnc;
    assign unused_dbnc = ^DBNC_CYCLES;
    assign lvl         = sync1;
`endif

    always_ff @(posedge core_clk) begin
        if (rst) begin
            lvl_d     <= 1'b0;
            start_vld <= 1'b0;
        end else begin
            lvl_d     <= lvl;
            start_vld <= lvl & ~lvl_d;
        end
    end

endmodule

// File: rtl/microprocessor_param.sv
// W-bit add/sub/mul/div processor: BTNU latches switches, 2W-bit result shown on LED (optional DEBOUNCE_EN).
// Latency: start pulse to DONE is 2 cycles for add/sub, W+1 for mul (shift-add) and div (restoring).
// Backpressure: start pulses arriving while BUSY are dropped, never queued.
module microprocessor_param
    import microprocessor_pkg::*;
#(
    parameter int W           = 4,
    parameter int DBNC_CYCLES = 1000000
) (
    input  logic           CLK100MHZ,
    input  logic           CPU_RESET,
    input  logic           BTNU,
    input  logic [W-1:0]   SW_A,
    input  logic [W-1:0]   SW_B,
    input  logic [1:0]     SW_OP,
    output logic [2*W-1:0] LED,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR
);

    localparam int CNT_W = $clog2(W);

    state_t           state;
    state_t           state_nxt;
    logic             start_vld;
    logic             accept;
    logic             last_step;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_nxt;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     rem;
    logic [W-1:0]     rem_nxt;
    logic [W-1:0]     quo;
    logic [W-1:0]     quo_nxt;
    logic [W:0]       div_shift;
    logic [W+1:0]     div_diff;
    logic [W:0]       sum;
    logic [W:0]       diff;
    logic [2*W-1:0]   res;

    btn_sync_edge #(
        .DBNC_CYCLES(DBNC_CYCLES)
    ) u_btn (
        .core_clk (CLK100MHZ),
        .rst      (CPU_RESET),
        .btn      (BTNU),
        .start_vld(start_vld)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = 1'b0;
        BUSY      = (state != ST_IDLE);
        DONE      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start_vld) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                last_step = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt == CNT_W'(W - 1));
                if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One shift-add and one restoring-divide step per EXEC cycle; the result mux picks by opcode.
    always_comb begin
        acc_nxt   = acc + (mplier[0] ? mcand : '0);
        div_shift = {rem, quo[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        rem_nxt   = div_diff[W+1] ? div_shift[W-1:0] : div_diff[W-1:0];
        quo_nxt   = {quo[W-2:0], ~div_diff[W+1]};
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD:  res = {{(W-1){1'b0}}, sum};
            OP_SUB:  res = {{(W-1){diff[W]}}, diff};
            OP_MUL:  res = acc_nxt;
            default: res = {rem_nxt, quo_nxt};
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            LED    <= '0;
            ERR    <= 1'b0;
        end else if (accept) begin
            a_q    <= SW_A;
            b_q    <= SW_B;
            op_q   <= SW_OP;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, SW_A};
            mplier <= SW_B;
            rem    <= '0;
            quo    <= SW_A;
            ERR    <= 1'b0;
        end else if (state == ST_EXEC) begin
            cnt    <= cnt + CNT_W'(1);
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            if (last_step) begin
                LED <= res;
                if (op_q == OP_DIV && b_q == '0) ERR <= 1'b1;
            end
        end
    end

endmodule
